// File: rtl/packet_source.sv
// -----------------------------------------------------------------------------
// packet_source
//
// Transmit end of the packet/credit NoC channel. It accepts whole 5-flit
// (160-bit) packets from a PE-side valid/ready interface and stamps an 18-bit
// serial into the header. It then serializes the packet header-first, one
// 32-bit flit per clock. Packet acceptance is gated by a packet-granular
// credit counter that the receiver replenishes with rising edges on credit_in.
//
// State table:
//   state | meaning
//   IDLE  | nothing in flight, channel driven to zero
//   SEND  | flit idx_q (0..4) of the registered packet is on the channel
//
// Ports:
//   clk                  system clock, rising edge
//   reset                synchronous, active-high reset
//   pkt_valid_in         packet offered on pkt_data_in
//   pkt_data_in[159:0]   [159:128] header (bits [145:128] replaced by serial),
//                        [127:0] four data flits, most significant first
//   pkt_ready_out        packet can be captured this cycle
//   credit_in            credit return; each 0->1 transition is one credit
//   channel_out[31:0]    flit channel, zero when idle
//   busy_out             a packet is being serialized
//   credit_count_out     current credits
//   credit_overflow_out  sticky: credit edge arrived while credits were full
//   packets_sent_out     completed packet count (wraps)
// -----------------------------------------------------------------------------
module packet_source #(
    parameter int CREDITS  = 4,
    parameter int CREDIT_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pkt_valid_in,
    input  logic [159:0]        pkt_data_in,
    output logic                pkt_ready_out,
    input  logic                credit_in,
    output logic [31:0]         channel_out,
    output logic                busy_out,
    output logic [CREDIT_W-1:0] credit_count_out,
    output logic                credit_overflow_out,
    output logic [31:0]         packets_sent_out
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(CREDITS);
    localparam logic [17:0]         SERIAL_MAX = 18'h3FFFF;
    localparam logic [2:0]          LAST_IDX   = 3'd4;

    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [159:0]          pkt_q, pkt_d;
    logic [17:0]           serial_q, serial_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  overflow_q, overflow_d;
    logic [31:0]           sent_q, sent_d;
    logic                  credit_in_q;

    logic                  last_flit;
    logic                  capture;
    logic                  credit_rise;

    // ---------------------------------------------------------------------
    // Handshake and event decode
    // ---------------------------------------------------------------------
    assign last_flit   = (state_q == ST_SEND) && (idx_q == LAST_IDX);
    // A new packet may be taken while idle, or on the last flit so that
    // back-to-back packets leave no bubble on the channel.
    assign pkt_ready_out = !reset && (credit_q != '0) &&
                           ((state_q == ST_IDLE) || last_flit);
    assign capture     = pkt_valid_in && pkt_ready_out;
    assign credit_rise = credit_in && !credit_in_q;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_SEND;
                    idx_d   = 3'd0;
                end
            end
            ST_SEND: begin
                if (idx_q == LAST_IDX) begin
                    idx_d = 3'd0;
                    if (!capture) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        channel_out = 32'd0;
        busy_out    = 1'b0;
        if (state_q == ST_SEND) begin
            busy_out = 1'b1;
            case (idx_q)
                3'd0:    channel_out = pkt_q[159:128];
                3'd1:    channel_out = pkt_q[127:96];
                3'd2:    channel_out = pkt_q[95:64];
                3'd3:    channel_out = pkt_q[63:32];
                3'd4:    channel_out = pkt_q[31:0];
                default: channel_out = 32'd0;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Datapath: packet capture, serial, credits, counters
    // ---------------------------------------------------------------------
    always_comb begin
        pkt_d    = pkt_q;
        serial_d = serial_q;
        if (capture) begin
            pkt_d = {pkt_data_in[159:146], serial_q, pkt_data_in[127:0]};
            // Zero is skipped so the header flit can never be all-zero;
            // the receiver relies on a non-zero channel to spot a packet.
            serial_d = (serial_q == SERIAL_MAX) ? 18'd1 : serial_q + 18'd1;
        end
    end

    always_comb begin
        credit_d   = credit_q;
        overflow_d = overflow_q;
        if (credit_rise && (credit_q == CREDIT_MAX)) begin
            overflow_d = 1'b1;
        end
        if (credit_rise && !capture) begin
            if (credit_q != CREDIT_MAX) begin
                credit_d = credit_q + CREDIT_W'(1);
            end
        end else if (capture && !credit_rise) begin
            credit_d = credit_q - CREDIT_W'(1);
        end
    end

    assign sent_d = last_flit ? sent_q + 32'd1 : sent_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_q       <= '0;
            serial_q    <= 18'd1;
            credit_q    <= CREDIT_MAX;
            overflow_q  <= 1'b0;
            sent_q      <= 32'd0;
            credit_in_q <= 1'b0;
        end else begin
            pkt_q       <= pkt_d;
            serial_q    <= serial_d;
            credit_q    <= credit_d;
            overflow_q  <= overflow_d;
            sent_q      <= sent_d;
            credit_in_q <= credit_in;
        end
    end

    assign credit_count_out    = credit_q;
    assign credit_overflow_out = overflow_q;
    assign packets_sent_out    = sent_q;

endmodule
